rr_arb8_idx: RTL and testbench

Eight-way round-robin arbiter that turns a request vector into a registered 3-bit grant index plus a valid flag. It sits directly upstream of the 3-to-8 decoder. `gnt_idx` drives the decoder select, and `gnt_vld` gates the decoded one-hot enables downstream. Fairness comes from a rotating priority pointer. A grant is held until the owner releases it.

---
 rtl/rr_arb8_idx.sv | 129 ++++++++++++
 tb/tb_rr_arb8_idx.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/rr_arb8_idx.sv
// rr_arb8_idx: eight-way round-robin arbiter with a registered 3-bit grant
// index and valid flag, feeding a 3-to-8 decoder downstream.
// Optional grant-hold limit enabled by the macro ARB_TIMEOUT_EN.
module rr_arb8_idx #(
  parameter int unsigned MAX_HOLD = 15  // 1..255, used only with ARB_TIMEOUT_EN
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic       done,
  output logic [2:0] gnt_idx,
  output logic       gnt_vld,
  output logic       timeout
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] ptr_q, ptr_d;
  logic [2:0] gnt_idx_q, gnt_idx_d;
  logic       timeout_q, timeout_d;

  // Request vector rotated so that bit 0 is the requester named by ptr_q.
  logic [7:0] rot_req;
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_rot
      assign rot_req[gi] = req[ptr_q + 3'(gi)];
    end
  endgenerate

  // Lowest set bit of the rotated vector = first requester at or after ptr.
  logic [2:0] rot_pick;
  always_comb begin
    rot_pick = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (rot_req[i]) rot_pick = 3'(i);
    end
  end

  logic [2:0] win_idx;
  logic       req_any;
  logic       release_ev;
  logic       hold_limit;

  assign win_idx    = ptr_q + rot_pick;
  assign req_any    = |req;
  // Owner finished or stopped asking; both together are one release.
  assign release_ev = done | ~req[gnt_idx_q];

`ifdef ARB_TIMEOUT_EN
  // hold_q counts completed GRANT cycles minus one; at MAX_HOLD-1 the
  // current cycle is the MAX_HOLD-th valid cycle, so the next edge revokes.
  logic [7:0] hold_q, hold_d;
  assign hold_limit = (hold_q == 8'(MAX_HOLD - 1));
`else
  logic [7:0] unused_max_hold;
  assign unused_max_hold = 8'(MAX_HOLD);
  assign hold_limit      = 1'b0;
`endif

  // Next-state logic: grant from IDLE, release or revoke from GRANT.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gnt_idx_d = gnt_idx_q;
    timeout_d = 1'b0;
`ifdef ARB_TIMEOUT_EN
    hold_d    = hold_q;
`endif
    case (state_q)
      ST_IDLE: begin
        // done is meaningless here; only req starts a grant.
        if (req_any) begin
          gnt_idx_d = win_idx;
          state_d   = ST_GRANT;
`ifdef ARB_TIMEOUT_EN
          hold_d    = 8'd0;
`endif
        end
      end
      ST_GRANT: begin
        // A genuine release wins over the hold limit, so no timeout pulse.
        if (release_ev) begin
          state_d = ST_IDLE;
          ptr_d   = gnt_idx_q + 3'd1;
        end else if (hold_limit) begin
          state_d   = ST_IDLE;
          ptr_d     = gnt_idx_q + 3'd1;
          timeout_d = 1'b1;
        end else begin
`ifdef ARB_TIMEOUT_EN
          hold_d = hold_q + 8'd1;
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register with synchronous reset that overrides a live grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      ptr_q     <= 3'd0;
      gnt_idx_q <= 3'd0;
      timeout_q <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      hold_q    <= 8'd0;
`endif
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gnt_idx_q <= gnt_idx_d;
      timeout_q <= timeout_d;
`ifdef ARB_TIMEOUT_EN
      hold_q    <= hold_d;
`endif
    end
  end

  assign gnt_idx = gnt_idx_q;
  assign gnt_vld = (state_q == ST_GRANT);
  assign timeout = timeout_q;

endmodule

// File: tb/tb_rr_arb8_idx.sv
// Bench for rr_arb8_idx: directed literal checks plus randomized traffic,
// all compared every cycle against a behavioural arbiter model.
module tb_rr_arb8_idx;

  localparam int MAX_HOLD = 4;
`ifdef ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic       done;
  logic [2:0] gnt_idx;
  logic       gnt_vld;
  logic       timeout;

  int vectors     = 0;
  int miscompares = 0;

  rr_arb8_idx #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .done    (done),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld),
    .timeout (timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural model: owner index, pointer, and how many cycles the
  // current grant has been visible.
  int m_idx = 0;
  int m_ptr = 0;
  int m_age = 0;
  bit m_vld = 1'b0;
  bit m_to  = 1'b0;
  bit m_ok  = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_idx = 0; m_ptr = 0; m_age = 0; m_vld = 1'b0; m_to = 1'b0; m_ok = 1'b1;
    end else if (!m_vld) begin
      m_to = 1'b0;
      if (req != 8'd0) begin
        for (int k = 0; k < 8; k++) begin
          if (!m_vld && req[(m_ptr + k) % 8]) begin
            m_idx = (m_ptr + k) % 8;
            m_vld = 1'b1;
            m_age = 1;
          end
        end
      end
    end else begin
      m_to = 1'b0;
      if (done || !req[m_idx]) begin
        m_vld = 1'b0;
        m_ptr = (m_idx + 1) % 8;
      end else if (TO_EN && m_age >= MAX_HOLD) begin
        m_vld = 1'b0;
        m_to  = 1'b1;
        m_ptr = (m_idx + 1) % 8;
      end else begin
        m_age = m_age + 1;
      end
    end
  end

  // Every-cycle comparison against the model, away from the rising edge.
  always @(negedge clk) begin
    if (m_ok) begin
      vectors++;
      if (gnt_vld !== m_vld || gnt_idx !== 3'(m_idx) || timeout !== m_to) begin
        miscompares++;
        $display("FAIL model t=%0t: got vld=%0b idx=%0d to=%0b, want vld=%0b idx=%0d to=%0b",
                 $time, gnt_vld, gnt_idx, timeout, m_vld, m_idx, m_to);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [2:0] idx_exp,
                     input logic vld_exp, input logic to_exp);
    vectors++;
    if (gnt_vld !== vld_exp || timeout !== to_exp ||
        (vld_exp && gnt_idx !== idx_exp)) begin
      miscompares++;
      $display("FAIL %s: got vld=%0b idx=%0d to=%0b, want vld=%0b idx=%0d to=%0b",
               name, gnt_vld, gnt_idx, timeout, vld_exp, idx_exp, to_exp);
    end
  endtask

  initial begin
    int r;
    rst = 1'b1; req = 8'd0; done = 1'b0;

    // 1: reset and single request
    step(); step();
    vectors++;
    if (gnt_vld !== 1'b0 || gnt_idx !== 3'd0 || timeout !== 1'b0) begin
      miscompares++;
      $display("FAIL reset: got vld=%0b idx=%0d to=%0b, want 0 0 0", gnt_vld, gnt_idx, timeout);
    end
    rst = 1'b0; req = 8'b0000_1000;
    step(); chk("single_grant", 3'd3, 1'b1, 1'b0);
    done = 1'b1;
    step(); chk("single_release", 3'd3, 1'b0, 1'b0);
    done = 1'b0; req = 8'd0;
    step();
    req = 8'hFF;
    step(); chk("ptr_after_3", 3'd4, 1'b1, 1'b0);

    // 2: round-robin rotation from ptr=0
    rst = 1'b1;
    step();
    rst = 1'b0;
    step(); chk("rr_first", 3'd0, 1'b1, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      done = 1'b1;
      step(); chk("rr_gap", 3'd0, 1'b0, 1'b0);
      done = 1'b0;
      step(); chk("rr_grant", 3'(k % 8), 1'b1, 1'b0);
    end

    // 3: wrap-around from ptr=7
    done = 1'b1;
    step();
    done = 1'b0; req = 8'b0100_0000;
    step(); chk("grant6", 3'd6, 1'b1, 1'b0);
    req = 8'd0;
    step(); chk("drop6", 3'd6, 1'b0, 1'b0);
    req = 8'b1000_0001;
    step(); chk("wrap7", 3'd7, 1'b1, 1'b0);
    done = 1'b1;
    step(); chk("wrap_gap", 3'd7, 1'b0, 1'b0);
    done = 1'b0;
    step(); chk("wrap0", 3'd0, 1'b1, 1'b0);

    // 4: drop-request release, then reset mid-grant
    done = 1'b1;
    step();
    done = 1'b0; req = 8'h20;
    step(); chk("grant5", 3'd5, 1'b1, 1'b0);
    req = 8'd0;
    step(); chk("drop5", 3'd5, 1'b0, 1'b0);
    req = 8'h20;
    step(); chk("regrant5", 3'd5, 1'b1, 1'b0);
    rst = 1'b1;
    step();
    vectors++;
    if (gnt_vld !== 1'b0 || gnt_idx !== 3'd0) begin
      miscompares++;
      $display("FAIL mid_reset: got vld=%0b idx=%0d, want vld=0 idx=0", gnt_vld, gnt_idx);
    end
    rst = 1'b0; req = 8'hFF;
    step(); chk("ptr_after_rst", 3'd0, 1'b1, 1'b0);
    done = 1'b1;
    step();
    done = 1'b0; req = 8'd0;
    step();

    // 5/6: hold limit, or unbounded hold in the plain build
    req = 8'h04;
    step(); chk("hold_grant2", 3'd2, 1'b1, 1'b0);
`ifdef ARB_TIMEOUT_EN
    for (int k = 0; k < MAX_HOLD - 1; k++) begin
      step(); chk("hold_live", 3'd2, 1'b1, 1'b0);
    end
    step(); chk("timeout_pulse", 3'd2, 1'b0, 1'b1);
    step(); chk("timeout_regrant", 3'd2, 1'b1, 1'b0);
`else
    for (int k = 0; k < 300; k++) begin
      step(); chk("no_timeout", 3'd2, 1'b1, 1'b0);
    end
`endif
    req = 8'd0;
    step();

    // Randomized traffic, checked by the model process
    for (int n = 0; n < 4000; n++) begin
      rst  = ($urandom_range(0, 199) == 0);
      done = ($urandom_range(0, 3) == 0);
      r = int'($urandom_range(0, 5));
      case (r)
        0:       req = 8'($urandom);
        1:       req = 8'd1 << $urandom_range(0, 7);
        2:       req = req ^ (8'd1 << $urandom_range(0, 7));
        3:       req = 8'd0;
        default: req = req;
      endcase
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
